// File: rtl/bram_read_arbiter.sv
// Two-requester burst read arbiter for a BRAM read port: round-robin grant,
// address sequencing, and a per-beat id/last tag pipeline matched to BRAM latency.
module bram_read_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 128,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [ADDR_W-1:0] req0_len,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [ADDR_W-1:0] req1_len,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              rd_valid,
    output logic              rd_id,
    output logic              rd_last,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              dbg_state
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic              last_gnt;
    logic              gnt_id;
    logic              hs;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] remain_q;
    logic              id_q;
    logic              issue_last;
    logic [RD_LAT-1:0] tag_v;
    logic [RD_LAT-1:0] tag_id;
    logic [RD_LAT-1:0] tag_last;
    logic [RD_LAT-1:0] tag_v_d;
    logic [RD_LAT-1:0] tag_id_d;
    logic [RD_LAT-1:0] tag_last_d;

    // Handshake: a request transfers in any cycle where valid and ready are both
    // high; ready is only offered in IDLE, to one requester, and never in reset.
    always_comb begin
        state_nxt  = state;
        hs         = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (req0_valid && req1_valid) gnt_id = ~last_gnt;
        else                          gnt_id = req1_valid;
        case (state)
            IDLE: begin
                if (rst_n && (req0_valid || req1_valid)) begin
                    hs         = 1'b1;
                    req0_ready = ~gnt_id;
                    req1_ready = gnt_id;
                    state_nxt  = BURST;
                end
            end
            BURST: begin
                if (remain_q == '0) state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            id_q     <= 1'b0;
            addr_q   <= '0;
            remain_q <= '0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                last_gnt <= gnt_id;
                id_q     <= gnt_id;
                addr_q   <= gnt_id ? req1_addr : req0_addr;
                remain_q <= gnt_id ? req1_len : req0_len;
            end else if (state == BURST) begin
                addr_q   <= addr_q + ONE;
                remain_q <= remain_q - ONE;
            end
        end
    end

    assign bram_en    = (state == BURST);
    assign bram_addr  = addr_q;
    assign issue_last = (state == BURST) && (remain_q == '0);
    assign dbg_state  = (state == BURST);

    // Tags enter at issue time and emerge RD_LAT cycles later alongside the data.
    if (RD_LAT > 1) begin : g_deep
        assign tag_v_d    = {tag_v[RD_LAT-2:0], bram_en};
        assign tag_id_d   = {tag_id[RD_LAT-2:0], id_q};
        assign tag_last_d = {tag_last[RD_LAT-2:0], issue_last};
    end else begin : g_shallow
        assign tag_v_d    = bram_en;
        assign tag_id_d   = id_q;
        assign tag_last_d = issue_last;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            tag_v    <= '0;
            tag_id   <= '0;
            tag_last <= '0;
        end else begin
            tag_v    <= tag_v_d;
            tag_id   <= tag_id_d;
            tag_last <= tag_last_d;
        end
    end

    assign rd_valid = tag_v[RD_LAT-1];
    assign rd_id    = tag_id[RD_LAT-1];
    assign rd_last  = tag_last[RD_LAT-1];
    assign rd_data  = rd_valid ? bram_dout : '0;
    assign busy     = (state == BURST) || (|tag_v);

endmodule
